// File: rtl/mna_axi_resp_driver_pkg.sv
// Shared MNA definitions for the response path.
// Holds the flit type codes, header field positions, AXI response codes,
// the response-driver FSM state encoding and a header decode helper.
package mna_axi_resp_driver_pkg;

  // Flit type field, flit[33:32]
  localparam logic [1:0] FLIT_HDR     = 2'b10;
  localparam logic [1:0] FLIT_PAYLOAD = 2'b01;

  // Header body field positions
  localparam int unsigned WRITE_BIT = 0;
  localparam int unsigned RESP_LSB  = 1;

  // AXI response codes
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_DATA = 2'd1,
    ST_B_OUT     = 2'd2,
    ST_R_OUT     = 2'd3
  } resp_state_e;

  // Extract the AXI response code carried in a header body.
  function automatic logic [1:0] hdr_resp(input logic [31:0] body);
    return body[RESP_LSB +: 2];
  endfunction

endpackage

// File: rtl/mna_axi_resp_driver_sat_counter.sv
// mna_sat_counter: parameterised-width up counter that stops at all-ones.
// Ports:
//   clk   - clock
//   rst   - synchronous active-high reset, clears count
//   inc   - increment request for this cycle
//   count - current count value, never wraps
module mna_sat_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/mna_axi_resp_driver.sv
// mna_axi_resp_driver: MNA response-flow stage. Consumes response flits from
// the NoC ejection port and drives the AXI4-Lite B or R channel. Malformed
// flit sequences raise a one-cycle proto_err pulse and are counted.
// Ports:
//   clk, rst             - clock, synchronous active-high reset
//   flit_in/valid/ready  - response flit stream from the NoC
//   bvalid/bready/bresp  - AXI write response channel
//   rvalid/rready/rdata/rresp - AXI read data channel
//   proto_err            - pulse, one cycle after a malformed flit is accepted
//   err_count            - saturating count of proto_err pulses
module mna_axi_resp_driver
  import mna_axi_resp_driver_pkg::*;
#(
  parameter int unsigned FLIT_W   = 34,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ERRCNT_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [FLIT_W-1:0]   flit_in,
  input  logic                flit_valid,
  output logic                flit_ready,
  output logic                bvalid,
  input  logic                bready,
  output logic [1:0]          bresp,
  output logic                rvalid,
  input  logic                rready,
  output logic [DATA_W-1:0]   rdata,
  output logic [1:0]          rresp,
  output logic                proto_err,
  output logic [ERRCNT_W-1:0] err_count
);

  resp_state_e state, state_n;

  logic [1:0]        flit_type;
  logic [DATA_W-1:0] flit_body;
  logic              hdr_write;
  logic [1:0]        hdr_code;
  logic              accept;
  logic              err_det;
  logic              ld_bresp;
  logic              ld_rresp;
  logic              ld_rdata;

  assign flit_type = flit_in[FLIT_W-1 -: 2];
  assign flit_body = flit_in[DATA_W-1:0];
  assign hdr_write = flit_body[WRITE_BIT];
  assign hdr_code  = hdr_resp(flit_body[31:0]);

  // Decoded from state only so the upstream ready never depends on valid.
  always_comb begin
    flit_ready = (state == ST_IDLE) || (state == ST_WAIT_DATA);
    bvalid     = (state == ST_B_OUT);
    rvalid     = (state == ST_R_OUT);
  end

  assign accept = flit_valid && flit_ready;

  always_comb begin
    state_n  = state;
    err_det  = 1'b0;
    ld_bresp = 1'b0;
    ld_rresp = 1'b0;
    ld_rdata = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (flit_type == FLIT_HDR) begin
            if (hdr_write) begin
              ld_bresp = 1'b1;
              state_n  = ST_B_OUT;
            end else begin
              ld_rresp = 1'b1;
              state_n  = ST_WAIT_DATA;
            end
          end else begin
            err_det = 1'b1;
          end
        end
      end
      ST_WAIT_DATA: begin
        if (accept) begin
          if (flit_type == FLIT_PAYLOAD) begin
            ld_rdata = 1'b1;
            state_n  = ST_R_OUT;
          end else if (flit_type == FLIT_HDR) begin
            // Pending read is abandoned; the new header is taken as in IDLE.
            err_det = 1'b1;
            if (hdr_write) begin
              ld_bresp = 1'b1;
              state_n  = ST_B_OUT;
            end else begin
              ld_rresp = 1'b1;
              state_n  = ST_WAIT_DATA;
            end
          end else begin
            err_det = 1'b1;
          end
        end
      end
      ST_B_OUT: begin
        if (bready) begin
          state_n = ST_IDLE;
        end
      end
      ST_R_OUT: begin
        if (rready) begin
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      bresp     <= '0;
      rresp     <= '0;
      rdata     <= '0;
      proto_err <= 1'b0;
    end else begin
      state     <= state_n;
      proto_err <= err_det;
      if (ld_bresp) bresp <= hdr_code;
      if (ld_rresp) rresp <= hdr_code;
      if (ld_rdata) rdata <= flit_body;
    end
  end

  mna_sat_counter #(
    .WIDTH(ERRCNT_W)
  ) u_err_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (err_det),
    .count(err_count)
  );

endmodule

// File: tb/tb_mna_axi_resp_driver.sv
module tb_mna_axi_resp_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic [33:0] flit_in;
  logic        flit_valid;
  logic        flit_ready;
  logic        bvalid;
  logic        bready;
  logic [1:0]  bresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        proto_err;
  logic [7:0]  err_count;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  always #5 clk = ~clk;

  mna_axi_resp_driver #(
    .FLIT_W  (34),
    .DATA_W  (32),
    .ERRCNT_W(8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flit_in   (flit_in),
    .flit_valid(flit_valid),
    .flit_ready(flit_ready),
    .bvalid    (bvalid),
    .bready    (bready),
    .bresp     (bresp),
    .rvalid    (rvalid),
    .rready    (rready),
    .rdata     (rdata),
    .rresp     (rresp),
    .proto_err (proto_err),
    .err_count (err_count)
  );

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; flit_in = '0; flit_valid = 1'b0; bready = 1'b0; rready = 1'b0;
    tick(); tick();
    n_total++; if ({bvalid, rvalid, proto_err} !== 3'b000) $display("FAIL reset_valids: got %b expected 000", {bvalid, rvalid, proto_err}); else n_pass++;
    n_total++; if ({bresp, rresp, rdata} !== 36'h0) $display("FAIL reset_data: got %h expected 0", {bresp, rresp, rdata}); else n_pass++;
    n_total++; if (err_count !== 8'h00) $display("FAIL reset_errcnt: got %h expected 00", err_count); else n_pass++;
    n_total++; if (flit_ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", flit_ready); else n_pass++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_write();
    flit_in = 34'h2_0000_0001; flit_valid = 1'b1; bready = 1'b1;
    tick();
    flit_valid = 1'b0;
    n_total++; if ({bvalid, bresp, rvalid, flit_ready} !== 5'b1_00_0_0) $display("FAIL write_bout: got %b expected 10000", {bvalid, bresp, rvalid, flit_ready}); else n_pass++;
    tick();
    n_total++; if ({bvalid, rvalid, flit_ready} !== 3'b001) $display("FAIL write_done: got %b expected 001", {bvalid, rvalid, flit_ready}); else n_pass++;
    bready = 1'b0;
  endtask

  task automatic test_read_backpressure();
    rready = 1'b0;
    flit_in = 34'h2_0000_0004; flit_valid = 1'b1;
    tick();
    n_total++; if ({rvalid, flit_ready} !== 2'b01) $display("FAIL read_wait: got %b expected 01", {rvalid, flit_ready}); else n_pass++;
    flit_in = 34'h1_DEAD_BEEF;
    tick();
    flit_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_total++;
      if ({rvalid, bvalid, flit_ready, rresp, rdata} !== {3'b100, 2'b10, 32'hDEADBEEF})
        $display("FAIL read_hold%0d: got %b %h expected 100 10 deadbeef", i, {rvalid, bvalid, flit_ready, rresp}, rdata);
      else n_pass++;
      if (i < 4) tick();
    end
    rready = 1'b1;
    tick();
    rready = 1'b0;
    n_total++; if ({rvalid, flit_ready} !== 2'b01) $display("FAIL read_done: got %b expected 01", {rvalid, flit_ready}); else n_pass++;
  endtask

  task automatic test_orphan_payload();
    flit_in = 34'h1_1234_5678; flit_valid = 1'b1;
    tick();
    flit_valid = 1'b0;
    n_total++; if ({proto_err, bvalid, rvalid, err_count} !== {3'b100, 8'h01}) $display("FAIL orphan_pulse: got %b cnt %h expected 100 cnt 01", {proto_err, bvalid, rvalid}, err_count); else n_pass++;
    tick();
    n_total++; if ({proto_err, flit_ready, err_count} !== {2'b01, 8'h01}) $display("FAIL orphan_after: got %b cnt %h expected 01 cnt 01", {proto_err, flit_ready}, err_count); else n_pass++;
  endtask

  task automatic test_hdr_in_wait();
    bready = 1'b0;
    flit_in = 34'h2_0000_0000; flit_valid = 1'b1;
    tick();
    flit_in = 34'h2_0000_0003;
    tick();
    flit_valid = 1'b0;
    n_total++; if ({proto_err, bvalid, bresp, rvalid, err_count} !== {4'b1_1_01, 1'b0, 8'h02}) $display("FAIL hdr_wait: got %b cnt %h expected 11010 cnt 02", {proto_err, bvalid, bresp, rvalid}, err_count); else n_pass++;
    bready = 1'b1;
    tick();
    bready = 1'b0;
    n_total++; if ({bvalid, rvalid, proto_err, flit_ready} !== 4'b0001) $display("FAIL hdr_wait_done: got %b expected 0001", {bvalid, rvalid, proto_err, flit_ready}); else n_pass++;
  endtask

  task automatic test_invalid_in_wait();
    flit_in = 34'h2_0000_0002; flit_valid = 1'b1;
    tick();
    flit_in = 34'h3_FFFF_FFFF;
    tick();
    n_total++; if ({proto_err, rvalid, flit_ready, err_count} !== {3'b101, 8'h03}) $display("FAIL invalid_wait: got %b cnt %h expected 101 cnt 03", {proto_err, rvalid, flit_ready}, err_count); else n_pass++;
    flit_in = 34'h1_0000_00A5;
    tick();
    flit_valid = 1'b0;
    n_total++; if ({rvalid, proto_err, rresp, rdata} !== {2'b10, 2'b01, 32'h0000_00A5}) $display("FAIL invalid_wait_data: got %b %h expected 10 01 000000a5", {rvalid, proto_err, rresp}, rdata); else n_pass++;
    rready = 1'b1;
    tick();
    rready = 1'b0;
  endtask

  task automatic test_back_to_back();
    flit_in = 34'h2_0000_0007; flit_valid = 1'b1; bready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_total++;
      if ({bvalid, flit_ready, bresp} !== ((i % 2 == 0) ? 4'b10_11 : 4'b01_11))
        $display("FAIL b2b_%0d: got %b expected %b", i, {bvalid, flit_ready, bresp}, ((i % 2 == 0) ? 4'b10_11 : 4'b01_11));
      else n_pass++;
    end
    flit_valid = 1'b0; bready = 1'b0;
    tick();
  endtask

  task automatic test_saturation();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    flit_in = 34'h1_0000_0000; flit_valid = 1'b1;
    for (int i = 0; i < 254; i++) @(posedge clk);
    #1;
    n_total++; if (err_count !== 8'hFE) $display("FAIL sat_254: got %h expected fe", err_count); else n_pass++;
    for (int i = 0; i < 6; i++) @(posedge clk);
    #1;
    flit_valid = 1'b0;
    n_total++; if (err_count !== 8'hFF) $display("FAIL sat_260: got %h expected ff", err_count); else n_pass++;
    tick();
    n_total++; if ({err_count, proto_err} !== {8'hFF, 1'b0}) $display("FAIL sat_hold: got %h %b expected ff 0", err_count, proto_err); else n_pass++;
  endtask

  task automatic test_mid_reset();
    rready = 1'b0;
    flit_in = 34'h2_0000_0002; flit_valid = 1'b1;
    tick();
    flit_in = 34'h1_CAFE_F00D;
    tick();
    flit_valid = 1'b0;
    n_total++; if ({rvalid, rdata} !== {1'b1, 32'hCAFEF00D}) $display("FAIL midrst_pre: got %b %h expected 1 cafef00d", rvalid, rdata); else n_pass++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_total++; if ({rvalid, bvalid, flit_ready, rresp, rdata, err_count} !== {3'b001, 2'b00, 32'h0, 8'h00}) $display("FAIL midrst_post: got %b %b %h %h expected 001 00 0 00", {rvalid, bvalid, flit_ready}, rresp, rdata, err_count); else n_pass++;
    flit_in = 34'h2_0000_0005; flit_valid = 1'b1; bready = 1'b0;
    tick();
    flit_valid = 1'b0;
    tick();
    n_total++; if ({bvalid, bresp, flit_ready} !== 4'b1_10_0) $display("FAIL midrst_write: got %b expected 1100", {bvalid, bresp, flit_ready}); else n_pass++;
    bready = 1'b1;
    tick();
    bready = 1'b0;
    n_total++; if ({bvalid, flit_ready} !== 2'b01) $display("FAIL midrst_write_done: got %b expected 01", {bvalid, flit_ready}); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_backpressure();
    test_orphan_payload();
    test_hdr_in_wait();
    test_invalid_in_wait();
    test_back_to_back();
    test_saturation();
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
